// File: rtl/serial_paralelo_idl_pkg.sv
// Physical-layer constants and types shared by the IDL serialiser, deserialiser
// and the byte striping / un-striping blocks.
package serial_paralelo_idl_pkg;

    localparam logic [7:0] COM = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rxState_e;

endpackage

// File: rtl/serial_paralelo_idl.sv
// Serial-to-parallel IDL receiver: bit-granular COM search, byte alignment over
// BC_COUNT consecutive COMs, then per-byte delivery with valid and idle flags.
module serial_paralelo_idl
    import serial_paralelo_idl_pkg::*;
#(
    parameter int BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       IDL
);

    localparam logic [3:0] BC_COUNT_C = 4'(BC_COUNT);

    rxState_e   state_q, state_d;
    logic [7:0] shift_q;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [3:0] comCnt_q, comCnt_d;
    logic [7:0] dataOut_q, dataOut_d;
    logic       validOut_q, validOut_d;
    logic       active_q, active_d;

    logic [7:0] window;
    logic       windowIsCom;
    logic       boundary;
    logic       lockEdge;

    assign window      = {shift_q[6:0], data_in};
    assign windowIsCom = (window == COM);
    assign boundary    = (bitCnt_q == 3'd7);

    // The edge that completes the final required COM; shared by both processes.
    always_comb begin
        lockEdge = 1'b0;
        if (state_q == SEARCH && windowIsCom && BC_COUNT_C == 4'd1) begin
            lockEdge = 1'b1;
        end else if (state_q == ALIGN && boundary && windowIsCom &&
                     (comCnt_q + 4'd1) >= BC_COUNT_C) begin
            lockEdge = 1'b1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_q    <= SEARCH;
            shift_q    <= 8'h00;
            bitCnt_q   <= 3'd0;
            comCnt_q   <= 4'd0;
            dataOut_q  <= 8'h00;
            validOut_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= window;
            bitCnt_q   <= bitCnt_d;
            comCnt_q   <= comCnt_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        comCnt_d = comCnt_q;
        unique case (state_q)
            SEARCH: begin
                if (windowIsCom) begin
                    bitCnt_d = 3'd0;
                    comCnt_d = 4'd1;
                    state_d  = lockEdge ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                bitCnt_d = bitCnt_q + 3'd1;
                if (boundary) begin
                    if (windowIsCom) begin
                        if (lockEdge) begin
                            comCnt_d = BC_COUNT_C;
                            state_d  = ACTIVE;
                        end else begin
                            comCnt_d = comCnt_q + 4'd1;
                        end
                    end else begin
                        // A broken run drops the whole count; this window is not re-searched.
                        comCnt_d = 4'd0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bitCnt_d = bitCnt_q + 3'd1;
            end
            default: begin
                state_d  = SEARCH;
                bitCnt_d = 3'd0;
                comCnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        dataOut_d  = dataOut_q;
        validOut_d = validOut_q;
        active_d   = active_q;
        if (lockEdge) begin
            active_d   = 1'b1;
            dataOut_d  = COM;
            validOut_d = 1'b0;
        end else if (state_q == ACTIVE && boundary) begin
            dataOut_d  = window;
            validOut_d = !windowIsCom;
        end
    end

    assign data_out  = dataOut_q;
    assign valid_out = validOut_q;
    assign active    = active_q;
    assign IDL       = ~active_q;

endmodule

// File: tb/tb_serial_paralelo_idl.sv
// Bench for serial_paralelo_idl: an edge-indexed behavioural model checked every
// cycle, plus directed byte streams with hand-computed expectations.
module tb_serial_paralelo_idl;

    localparam int         BC  = 4;
    localparam logic [7:0] COMB = 8'hBC;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       IDL;

    int nChecks = 0;
    int nFails  = 0;

    serial_paralelo_idl #(.BC_COUNT(BC)) dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active),
        .IDL      (IDL)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    // Model: track the last eight bits and the edge at which the current COM
    // alignment was anchored; byte boundaries are every 8th edge after it.
    int         edgeCount = 0;
    int         anchorEdge = 0;
    int         runLen = 0;
    int         mode = 0;
    bit         modelKnown = 1'b0;
    logic [7:0] hist = 8'h00;
    logic [7:0] expData = 8'h00;
    logic       expValid = 1'b0;
    logic       expActive = 1'b0;

    always @(posedge clk_32f) begin
        bit atBoundary;
        edgeCount = edgeCount + 1;
        if (!reset_L) begin
            modelKnown = 1'b1;
            mode       = 0;
            runLen     = 0;
            hist       = 8'h00;
            expData    = 8'h00;
            expValid   = 1'b0;
            expActive  = 1'b0;
        end else begin
            hist       = {hist[6:0], data_in};
            atBoundary = (mode != 0) && (((edgeCount - anchorEdge) % 8) == 0);
            if (mode == 0) begin
                if (hist == COMB) begin
                    anchorEdge = edgeCount;
                    runLen     = 1;
                    mode       = 1;
                end
            end else if (mode == 1) begin
                if (atBoundary) begin
                    if (hist == COMB) runLen = runLen + 1;
                    else begin
                        runLen = 0;
                        mode   = 0;
                    end
                end
            end else if (atBoundary) begin
                expData  = hist;
                expValid = (hist != COMB);
            end
            if (mode == 1 && runLen == BC) begin
                mode      = 2;
                expActive = 1'b1;
                expData   = COMB;
                expValid  = 1'b0;
            end
        end
    end

    always @(negedge clk_32f) begin
        if (modelKnown) begin
            nChecks = nChecks + 1;
            if ({data_out, valid_out, active, IDL} !== {expData, expValid, expActive, ~expActive}) begin
                nFails = nFails + 1;
                $display("[TB] FAIL model@edge%0d: got data=%h valid=%b active=%b IDL=%b, expected data=%h valid=%b active=%b IDL=%b",
                         edgeCount, data_out, valid_out, active, IDL, expData, expValid, expActive, ~expActive);
            end
        end
    end

    task automatic applyBit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        @(negedge clk_32f);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) applyBit(b[i]);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eData,
                               input logic eValid, input logic eActive);
        nChecks = nChecks + 1;
        if ({data_out, valid_out, active, IDL} !== {eData, eValid, eActive, ~eActive}) begin
            nFails = nFails + 1;
            $display("[TB] FAIL %s: got data=%h valid=%b active=%b IDL=%b, expected data=%h valid=%b active=%b IDL=%b",
                     name, data_out, valid_out, active, IDL, eData, eValid, eActive, ~eActive);
        end
    endtask

    task automatic pulseReset(input int edges);
        reset_L = 1'b0;
        for (int i = 0; i < edges; i++) applyBit(1'($urandom_range(0, 1)));
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        data_in = 1'b0;
        @(negedge clk_32f);

        pulseReset(3);
        checkOutput("reset", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(8'hBC);
        checkOutput("aligned_3com", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        checkOutput("aligned_lock", 8'hBC, 1'b0, 1'b1);
        applyStimulus(8'h5A);
        checkOutput("data_5A", 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) applyBit(COMB[7-i]);
        checkOutput("hold_5A", 8'h5A, 1'b1, 1'b1);
        applyBit(COMB[0]);
        checkOutput("com_active", 8'hBC, 1'b0, 1'b1);
        applyStimulus(8'h3C);
        checkOutput("data_3C", 8'h3C, 1'b1, 1'b1);

        pulseReset(2);
        checkOutput("reset_again", 8'h00, 1'b0, 1'b0);
        applyBit(1'b1); applyBit(1'b0); applyBit(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC);
        checkOutput("misaligned_lock", 8'hBC, 1'b0, 1'b1);
        applyStimulus(8'hA5);
        checkOutput("misaligned_A5", 8'hA5, 1'b1, 1'b1);

        pulseReset(1);
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC);
        applyStimulus(8'h00);
        checkOutput("broken_run", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC);
        checkOutput("second_run_3", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        checkOutput("second_run_lock", 8'hBC, 1'b0, 1'b1);

        applyStimulus(8'hFF);
        checkOutput("data_FF", 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyBit(1'b1);
        reset_L = 1'b0;
        applyBit(1'b1);
        reset_L = 1'b1;
        checkOutput("reset_mid_active", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hFF);
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC);
        checkOutput("relock_3", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        checkOutput("relock", 8'hBC, 1'b0, 1'b1);
        applyStimulus(8'hC3);
        checkOutput("data_C3", 8'hC3, 1'b1, 1'b1);

        applyBit(1'b0);
        applyBit(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
